// File: rtl/line_band_detector.sv
// line_band_detector
// Counts lane-colour pixels in NUM_BANDS equal horizontal bands of the bottom
// ROI of each frame. On the vsync rising edge the bands are compared one per
// cycle against a width-scaled coverage threshold, then a coverage mask and a
// partial-break flag are published together with a one-cycle valid strobe.
//
// Build option LINE_BAND_PERSIST_EN: when defined, break_flag only changes
// after PERSIST consecutive frames disagree with it; when undefined,
// break_flag follows the raw per-frame result and PERSIST has no effect.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | measuring geometry, counting hits, waiting for vsync rise
// EVAL  | one band per cycle: latch coverage bit, clear its counter
// DONE  | publish band_ok / break_flag, pulse valid, clear band tracking

module line_band_detector #(
    parameter int ROI_LINES = 40,
    parameter int NUM_BANDS = 4,
    parameter int COVER_PCT = 8,
    parameter int CNT_W     = 24,
    parameter int PERSIST   = 3
) (
    input  logic                 pclk,
    input  logic                 reset,
    input  logic                 vsync,
    input  logic                 href,
    input  logic                 we,
    input  logic                 pix_hit,
    output logic [NUM_BANDS-1:0] band_ok,
    output logic                 break_flag,
    output logic                 valid_pulse,
    output logic [15:0]          width_px,
    output logic [15:0]          height_ln
);
    localparam int BAND_H = ROI_LINES / NUM_BANDS;
    localparam int BL_W   = (BAND_H > 1) ? $clog2(BAND_H) : 1;
    localparam int BI_W   = $clog2(NUM_BANDS + 1);
    localparam int EI_W   = $clog2(NUM_BANDS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;
    state_t state, state_nxt;

    logic                 vsync_d;
    logic [15:0]          x_cnt;
    logic [15:0]          y_cnt;
    logic [BL_W-1:0]      band_line;
    logic [BI_W-1:0]      band_idx;
    logic [EI_W-1:0]      eval_idx;
    logic [CNT_W-1:0]     cnt [NUM_BANDS];
    logic [NUM_BANDS-1:0] ok_sh;
    logic [31:0]          th;

    logic        vs_rise;
    logic        pix_valid;
    logic        line_end;
    logic        in_roi;
    logic        hit_en;
    logic        raw_break;
    logic [15:0] roi_top;
    logic [15:0] wp;
    logic [31:0] th_nxt;

    assign vs_rise   = vsync && !vsync_d;
    assign pix_valid = we && href && !vsync;
    assign line_end  = !href && (x_cnt != 16'd0);
    // ROI placement comes from the previous frame's height; 0 means top lines
    assign roi_top   = (height_ln > 16'(ROI_LINES)) ? (height_ln - 16'(ROI_LINES)) : 16'd0;
    assign in_roi    = (y_cnt >= roi_top) && (band_idx < BI_W'(NUM_BANDS));
    assign hit_en    = pix_valid && pix_hit && in_roi && (state == IDLE);
    assign wp        = (width_px == 16'd0) ? 16'd1 : width_px;
    assign th_nxt    = (32'(wp) * 32'(BAND_H) * 32'(COVER_PCT)) / 32'd100;
    assign raw_break = (ok_sh != '0) && (ok_sh != '1);

    // FSM state register
    always_ff @(posedge pclk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state: a vsync edge in IDLE starts one band-per-cycle evaluation
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vs_rise) state_nxt = EVAL;
            EVAL:    if (eval_idx == EI_W'(NUM_BANDS - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Line width / frame height measurement
    always_ff @(posedge pclk) begin
        if (reset) begin
            // Track vsync through reset so a level already high is not an edge
            vsync_d   <= vsync;
            x_cnt     <= '0;
            y_cnt     <= '0;
            width_px  <= '0;
            height_ln <= '0;
        end else begin
            vsync_d <= vsync;
            if (pix_valid) begin
                x_cnt <= x_cnt + 16'd1;
            end else if (line_end) begin
                width_px <= x_cnt;
                x_cnt    <= '0;
                y_cnt    <= y_cnt + 16'd1;
            end
            if (vs_rise) begin
                height_ln <= y_cnt;
                y_cnt     <= '0;
            end
        end
    end

    // Band position: counts lines inside the ROI without dividing by BAND_H
    always_ff @(posedge pclk) begin
        if (reset || (state == DONE)) begin
            band_line <= '0;
            band_idx  <= '0;
        end else if (line_end && (y_cnt >= roi_top) && (band_idx < BI_W'(NUM_BANDS))) begin
            if (band_line == BL_W'(BAND_H - 1)) begin
                band_line <= '0;
                band_idx  <= band_idx + BI_W'(1);
            end else begin
                band_line <= band_line + BL_W'(1);
            end
        end
    end

    // Per-band saturating hit counters; EVAL reads and clears one per cycle
    always_ff @(posedge pclk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BANDS; i++) cnt[i] <= '0;
            ok_sh    <= '0;
            th       <= '0;
            eval_idx <= '0;
        end else begin
            if ((state == IDLE) && vs_rise) begin
                th       <= th_nxt;
                eval_idx <= '0;
            end
            if (state == EVAL) eval_idx <= eval_idx + EI_W'(1);
            for (int i = 0; i < NUM_BANDS; i++) begin
                if ((state == EVAL) && (eval_idx == EI_W'(i))) begin
                    ok_sh[i] <= (32'(cnt[i]) > th);
                    cnt[i]   <= '0;
                end else if (hit_en && (band_idx == BI_W'(i)) && (cnt[i] != CNT_MAX)) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef LINE_BAND_PERSIST_EN
    logic [3:0] pers_cnt;

    // Publish results; break_flag flips only after PERSIST disagreeing frames
    always_ff @(posedge pclk) begin
        if (reset) begin
            band_ok     <= '0;
            break_flag  <= 1'b0;
            valid_pulse <= 1'b0;
            pers_cnt    <= '0;
        end else begin
            valid_pulse <= (state == DONE);
            if (state == DONE) begin
                band_ok <= ok_sh;
                if (raw_break == break_flag) begin
                    pers_cnt <= '0;
                end else if (pers_cnt >= 4'(PERSIST - 1)) begin
                    break_flag <= ~break_flag;
                    pers_cnt   <= '0;
                end else begin
                    pers_cnt <= pers_cnt + 4'd1;
                end
            end
        end
    end
`else
    // PERSIST has no effect without the debounce filter
    logic persist_unused;
    assign persist_unused = (PERSIST > 0);

    // Publish results; break_flag follows each frame's raw result
    always_ff @(posedge pclk) begin
        if (reset) begin
            band_ok     <= '0;
            break_flag  <= 1'b0;
            valid_pulse <= 1'b0;
        end else begin
            valid_pulse <= (state == DONE);
            if (state == DONE) begin
                band_ok    <= ok_sh;
                break_flag <= raw_break;
            end
        end
    end
`endif

endmodule

// File: tb/tb_line_band_detector.sv
// Self-checking bench for line_band_detector (ROI 8 lines, 4 bands, 8 %).
`timescale 1ns/1ps
module tb_line_band_detector;
    localparam int ROI_LINES = 8;
    localparam int NUM_BANDS = 4;
    localparam int COVER_PCT = 8;
    localparam int CNT_W     = 24;
    localparam int PERSIST   = 3;
    localparam int BAND_H    = ROI_LINES / NUM_BANDS;

    logic pclk = 1'b0;
    logic reset, vsync, href, we, pix_hit;
    logic [NUM_BANDS-1:0] band_ok;
    logic break_flag, valid_pulse;
    logic [15:0] width_px, height_ln;

    line_band_detector #(
        .ROI_LINES(ROI_LINES), .NUM_BANDS(NUM_BANDS), .COVER_PCT(COVER_PCT),
        .CNT_W(CNT_W), .PERSIST(PERSIST)
    ) dut (
        .pclk(pclk), .reset(reset), .vsync(vsync), .href(href), .we(we),
        .pix_hit(pix_hit), .band_ok(band_ok), .break_flag(break_flag),
        .valid_pulse(valid_pulse), .width_px(width_px), .height_ln(height_ln)
    );

    always #5 pclk = ~pclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Pulse monitor: latency is counted in pclk edges from the vsync-rise edge
    int   cyc = 0;
    int   rise_cyc = 0;
    logic vs_prev = 1'b0;
    int                   q_lat[$];
    logic [NUM_BANDS-1:0] q_ok[$];
    logic                 q_brk[$];

    always @(posedge pclk) begin
        cyc     <= cyc + 1;
        vs_prev <= vsync;
        if (vsync && !vs_prev) rise_cyc <= cyc + 1;
    end

    always @(negedge pclk) begin
        if (valid_pulse) begin
            q_lat.push_back(cyc - rise_cyc);
            q_ok.push_back(band_ok);
            q_brk.push_back(break_flag);
        end
    end

    // Reference model state (frame-level view of the detector)
    int   m_height = 0;
    int   m_width  = 0;
    logic m_flag   = 1'b0;
    int   m_run    = 0;
    int   line_hits[64];
    logic [NUM_BANDS-1:0] exp_ok;
    logic exp_brk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // One line of w strobed pixels, exactly min(hits,w) of them lane-coloured
    task automatic drive_line(input int w, input int hits);
        int r = hits;
        int q = w;
        href = 1'b1;
        while (q > 0) begin
            we = ($urandom_range(0, 3) != 0);
            if (we) begin
                pix_hit = (r > 0) && ($urandom_range(0, q - 1) < r);
                if (pix_hit) r--;
                q--;
            end else begin
                pix_hit = 1'($urandom_range(0, 1));
            end
            tick();
        end
        href = 1'b0;
        we   = 1'b0;
        repeat (3) begin
            pix_hit = 1'($urandom_range(0, 1));
            tick();
        end
        pix_hit = 1'b0;
    endtask

    // Drives h lines from line_hits, predicts the result, then a vsync burst
    task automatic run_frame(input int h, input int w, input int vs_len, input int reset_at);
        int   roi_top, th, wm;
        int   bc[NUM_BANDS];
        logic raw;
        q_lat.delete(); q_ok.delete(); q_brk.delete();
        for (int y = 0; y < h; y++) drive_line(w, line_hits[y]);
        roi_top = (m_height > ROI_LINES) ? m_height - ROI_LINES : 0;
        foreach (bc[b]) bc[b] = 0;
        for (int y = 0; y < h; y++)
            if (y >= roi_top && (y - roi_top) < ROI_LINES)
                bc[(y - roi_top) / BAND_H] += (line_hits[y] < w) ? line_hits[y] : w;
        if (h > 0) m_width = w;
        wm = (m_width == 0) ? 1 : m_width;
        th = (wm * BAND_H * COVER_PCT) / 100;
        for (int b = 0; b < NUM_BANDS; b++) exp_ok[b] = (bc[b] > th);
        m_height = h;
        raw = (exp_ok != '0) && (exp_ok != '1);
`ifdef LINE_BAND_PERSIST_EN
        if (raw != m_flag) begin
            m_run++;
            if (m_run >= PERSIST) begin m_flag = ~m_flag; m_run = 0; end
        end else begin
            m_run = 0;
        end
`else
        m_flag = raw;
`endif
        exp_brk = m_flag;
        vsync = 1'b1;
        for (int c = 0; c < vs_len; c++) begin
            reset   = (c == reset_at);
            href    = 1'($urandom_range(0, 1));
            we      = 1'($urandom_range(0, 1));
            pix_hit = 1'($urandom_range(0, 1));
            tick();
        end
        reset = 1'b0; href = 1'b0; we = 1'b0; pix_hit = 1'b0; vsync = 1'b0;
        if (reset_at >= 0 && reset_at < vs_len) begin
            m_height = 0; m_width = 0; m_flag = 1'b0; m_run = 0;
        end
        repeat (12) tick();
    endtask

    // Fills a 16-line frame whose ROI is lines 8..15; per-band totals given
    task automatic set_bands(input int b0, input int b1, input int b2, input int b3);
        int tot[NUM_BANDS];
        tot[0] = b0; tot[1] = b1; tot[2] = b2; tot[3] = b3;
        for (int y = 0; y < 8; y++) line_hits[y] = $urandom_range(0, 64);
        for (int b = 0; b < NUM_BANDS; b++) begin
            line_hits[8 + 2 * b] = (tot[b] + 1) / 2;
            line_hits[9 + 2 * b] = tot[b] / 2;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; vsync = 1'b0; href = 1'b0; we = 1'b0; pix_hit = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        n_tests++; if (band_ok !== '0)      begin n_fail++; $display("FAIL reset_band_ok got %b want 0", band_ok); end
        n_tests++; if (break_flag !== 1'b0) begin n_fail++; $display("FAIL reset_break got %b want 0", break_flag); end
        n_tests++; if (valid_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_pulse); end
        n_tests++; if (width_px !== 16'd0)  begin n_fail++; $display("FAIL reset_width got %0d want 0", width_px); end
        n_tests++; if (height_ln !== 16'd0) begin n_fail++; $display("FAIL reset_height got %0d want 0", height_ln); end
    endtask

    task automatic test_warmup();
        for (int y = 0; y < 16; y++) line_hits[y] = $urandom_range(0, 64);
        run_frame(16, 64, 10, -1);
        n_tests++;
        if (q_ok.size() != 1) begin n_fail++; $display("FAIL warmup_pulses got %0d want 1", q_ok.size()); end
        else begin
            n_tests++; if (q_lat[0] != NUM_BANDS + 1) begin n_fail++; $display("FAIL warmup_latency got %0d want %0d", q_lat[0], NUM_BANDS + 1); end
            n_tests++; if (q_ok[0] !== exp_ok)  begin n_fail++; $display("FAIL warmup_band_ok got %b want %b", q_ok[0], exp_ok); end
            n_tests++; if (q_brk[0] !== exp_brk) begin n_fail++; $display("FAIL warmup_break got %b want %b", q_brk[0], exp_brk); end
        end
        n_tests++; if (height_ln !== 16'd16) begin n_fail++; $display("FAIL warmup_height got %0d want 16", height_ln); end
        n_tests++; if (width_px !== 16'd64)  begin n_fail++; $display("FAIL warmup_width got %0d want 64", width_px); end
    endtask

    task automatic test_all_bands();
        set_bands(20, 20, 20, 20);
        run_frame(16, 64, 10, -1);
        n_tests++;
        if (q_ok.size() != 1) begin n_fail++; $display("FAIL all_pulses got %0d want 1", q_ok.size()); end
        else begin
            n_tests++; if (q_lat[0] != NUM_BANDS + 1) begin n_fail++; $display("FAIL all_latency got %0d want %0d", q_lat[0], NUM_BANDS + 1); end
            n_tests++; if (q_ok[0] !== 4'b1111) begin n_fail++; $display("FAIL all_band_ok got %b want 1111", q_ok[0]); end
            n_tests++; if (q_brk[0] !== 1'b0)   begin n_fail++; $display("FAIL all_break got %b want 0", q_brk[0]); end
        end
    endtask

    task automatic test_threshold();
        for (int n = 10; n <= 11; n++) begin
            set_bands(20, 20, n, 20);
            run_frame(16, 64, 10, -1);
            n_tests++;
            if (q_ok.size() != 1) begin n_fail++; $display("FAIL thresh%0d_pulses got %0d want 1", n, q_ok.size()); end
            else begin
                n_tests++; if (q_ok[0][2] !== (n == 11)) begin n_fail++; $display("FAIL thresh%0d_band2 got %b want %b", n, q_ok[0][2], (n == 11)); end
                n_tests++; if (q_ok[0] !== exp_ok)   begin n_fail++; $display("FAIL thresh%0d_band_ok got %b want %b", n, q_ok[0], exp_ok); end
                n_tests++; if (q_brk[0] !== exp_brk) begin n_fail++; $display("FAIL thresh%0d_break got %b want %b", n, q_brk[0], exp_brk); end
            end
        end
    endtask

    // Three half-covered frames then three fully covered frames
    task automatic test_partial();
        logic [5:0] seq;
`ifdef LINE_BAND_PERSIST_EN
        seq = 6'b011100;
`else
        seq = 6'b000111;
`endif
        for (int f = 0; f < 6; f++) begin
            if (f < 3) set_bands(20, 20, 0, 0);
            else       set_bands(20, 20, 20, 20);
            run_frame(16, 64, 10, -1);
            n_tests++;
            if (q_ok.size() != 1) begin n_fail++; $display("FAIL partial%0d_pulses got %0d want 1", f, q_ok.size()); end
            else begin
                n_tests++; if (q_ok[0] !== ((f < 3) ? 4'b0011 : 4'b1111)) begin n_fail++; $display("FAIL partial%0d_band_ok got %b", f, q_ok[0]); end
                n_tests++; if (q_brk[0] !== seq[f]) begin n_fail++; $display("FAIL partial%0d_break got %b want %b", f, q_brk[0], seq[f]); end
            end
        end
    endtask

    task automatic test_long_vsync();
        set_bands($urandom_range(0, 30), $urandom_range(0, 30), $urandom_range(0, 30), $urandom_range(0, 30));
        run_frame(16, 64, 50, -1);
        n_tests++;
        if (q_ok.size() != 1) begin n_fail++; $display("FAIL longvs_pulses got %0d want 1", q_ok.size()); end
        else begin
            n_tests++; if (q_lat[0] != NUM_BANDS + 1) begin n_fail++; $display("FAIL longvs_latency got %0d want %0d", q_lat[0], NUM_BANDS + 1); end
            n_tests++; if (q_ok[0] !== exp_ok)  begin n_fail++; $display("FAIL longvs_band_ok got %b want %b", q_ok[0], exp_ok); end
            n_tests++; if (q_brk[0] !== exp_brk) begin n_fail++; $display("FAIL longvs_break got %b want %b", q_brk[0], exp_brk); end
        end
        n_tests++; if (height_ln !== 16'd16) begin n_fail++; $display("FAIL longvs_height got %0d want 16", height_ln); end
        n_tests++; if (width_px !== 16'd64)  begin n_fail++; $display("FAIL longvs_width got %0d want 64", width_px); end
    endtask

    // Reset lands on the T2 edge; the following short frame must evaluate
    task automatic test_reset_mid_eval();
        set_bands(20, 20, 20, 20);
        run_frame(16, 64, 10, 2);
        n_tests++; if (q_ok.size() != 0)     begin n_fail++; $display("FAIL rst_eval_pulses got %0d want 0", q_ok.size()); end
        n_tests++; if (band_ok !== '0)       begin n_fail++; $display("FAIL rst_eval_band_ok got %b want 0", band_ok); end
        n_tests++; if (break_flag !== 1'b0)  begin n_fail++; $display("FAIL rst_eval_break got %b want 0", break_flag); end
        n_tests++; if (width_px !== 16'd0)   begin n_fail++; $display("FAIL rst_eval_width got %0d want 0", width_px); end
        n_tests++; if (height_ln !== 16'd0)  begin n_fail++; $display("FAIL rst_eval_height got %0d want 0", height_ln); end
        for (int y = 0; y < 5; y++) line_hits[y] = 10;
        run_frame(5, 64, 10, -1);
        n_tests++;
        if (q_ok.size() != 1) begin n_fail++; $display("FAIL post_rst_pulses got %0d want 1", q_ok.size()); end
        else begin
            n_tests++; if (q_ok[0] !== 4'b0011) begin n_fail++; $display("FAIL post_rst_band_ok got %b want 0011", q_ok[0]); end
            n_tests++; if (q_brk[0] !== exp_brk) begin n_fail++; $display("FAIL post_rst_break got %b want %b", q_brk[0], exp_brk); end
        end
        n_tests++; if (height_ln !== 16'd5) begin n_fail++; $display("FAIL post_rst_height got %0d want 5", height_ln); end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 8; f++) begin
            int h = $urandom_range(3, 20);
            int w = $urandom_range(8, 40);
            for (int y = 0; y < h; y++) line_hits[y] = $urandom_range(0, w / 6);
            run_frame(h, w, $urandom_range(2, 30), -1);
            n_tests++;
            if (q_ok.size() != 1) begin n_fail++; $display("FAIL rand%0d_pulses got %0d want 1", f, q_ok.size()); end
            else begin
                n_tests++; if (q_lat[0] != NUM_BANDS + 1) begin n_fail++; $display("FAIL rand%0d_latency got %0d want %0d", f, q_lat[0], NUM_BANDS + 1); end
                n_tests++; if (q_ok[0] !== exp_ok)  begin n_fail++; $display("FAIL rand%0d_band_ok got %b want %b", f, q_ok[0], exp_ok); end
                n_tests++; if (q_brk[0] !== exp_brk) begin n_fail++; $display("FAIL rand%0d_break got %b want %b", f, q_brk[0], exp_brk); end
            end
            n_tests++; if (height_ln !== 16'(h)) begin n_fail++; $display("FAIL rand%0d_height got %0d want %0d", f, height_ln, h); end
            n_tests++; if (width_px !== 16'(w))  begin n_fail++; $display("FAIL rand%0d_width got %0d want %0d", f, width_px, w); end
        end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_all_bands();
        test_threshold();
        test_partial();
        test_long_vsync();
        test_reset_mid_eval();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
